// File: rtl/stall_flush_ctrl_if.sv
// stall_flush_ctrl_if -- hazard requests into, and pipeline-register controls
// out of, the stall/flush controller.
//   master : pipeline side, drives hazard/stall requests, receives controls
//   slave  : controller side, receives requests, drives stall/flush/div_busy/stall_cnt
interface stall_flush_ctrl_if;
    logic        stcl_lw;
    logic        stcl_jmp;
    logic        icache_stall;
    logic        dcache_stall;
    logic        div_start;
    logic        exc_flush;
    logic        pc_stall;
    logic        if_id_stall;
    logic        id_exe_stall;
    logic        exe_mem_stall;
    logic        if_id_flush;
    logic        id_exe_flush;
    logic        exe_mem_flush;
    logic        mem_wb_flush;
    logic        div_busy;
    logic [31:0] stall_cnt;

    modport master (
        output stcl_lw, stcl_jmp, icache_stall, dcache_stall, div_start, exc_flush,
        input  pc_stall, if_id_stall, id_exe_stall, exe_mem_stall,
        input  if_id_flush, id_exe_flush, exe_mem_flush, mem_wb_flush,
        input  div_busy, stall_cnt
    );

    modport slave (
        input  stcl_lw, stcl_jmp, icache_stall, dcache_stall, div_start, exc_flush,
        output pc_stall, if_id_stall, id_exe_stall, exe_mem_stall,
        output if_id_flush, id_exe_flush, exe_mem_flush, mem_wb_flush,
        output div_busy, stall_cnt
    );
endinterface

// File: rtl/stall_flush_ctrl.sv
// stall_flush_ctrl -- prioritised stall/flush generation for a 5-stage pipeline,
// with an optional multicycle-divide hold FSM and a saturating stall counter.
// Ports:
//   clk   : single clock, rising edge
//   rst_n : synchronous active-low reset
//   sif   : stall_flush_ctrl_if.slave (hazard requests in; stall/flush,
//           div_busy and stall_cnt out)
// Parameter DIV_CYCLES (2..63): cycles a divide holds EXE.
// Build option: define DIV_STALL_EN to include the divide FSM; otherwise
// div_start is ignored and div_busy is tied low.
module stall_flush_ctrl #(
    parameter int unsigned DIV_CYCLES = 33
) (
    input  logic              clk,
    input  logic              rst_n,
    stall_flush_ctrl_if.slave sif
);

    logic        div_busy_w;
    logic [7:0]  ctl;   // {pc, if_id, id_exe, exe_mem stalls, if_id, id_exe, exe_mem, mem_wb flushes}
    logic [31:0] stall_cnt_q, stall_cnt_d;

`ifdef DIV_STALL_EN
    typedef enum logic {IDLE, DIV} div_state_e;

    div_state_e state_q, state_d;
    logic [5:0] div_cnt_q, div_cnt_d;
    logic       div_busy_q, div_busy_d;

    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        if (sif.exc_flush) begin
            state_d   = IDLE;
            div_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sif.div_start && !sif.dcache_stall) begin
                        state_d   = DIV;
                        div_cnt_d = 6'(DIV_CYCLES - 1);
                    end
                end
                DIV: begin
                    // Counts down even while dcache holds the pipe.
                    if (div_cnt_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        div_cnt_d = div_cnt_q - 6'd1;
                    end
                end
            endcase
        end
        div_busy_d = (state_d == DIV);
    end

    // Registered state is invisible until the first reset edge, so gate it.
    assign div_busy_w = div_busy_q & rst_n;
`else
    logic unused_div;
    assign unused_div = ^{sif.div_start, DIV_CYCLES[0]};
    assign div_busy_w = 1'b0;
`endif

    // Highest active source wins; each lower-priority source only applies
    // when nothing above it is active.
    always_comb begin
        ctl = '0;
        if (!rst_n) begin
            ctl = '0;
        end else if (sif.exc_flush) begin
            ctl = 8'b0000_1111;
        end else if (sif.dcache_stall) begin
            ctl = 8'b1111_0001;
        end else if (div_busy_w) begin
            ctl = 8'b1110_0010;
        end else if (sif.stcl_lw || sif.stcl_jmp) begin
            ctl = 8'b1100_0100;
        end else if (sif.icache_stall) begin
            ctl = 8'b1000_1000;
        end
    end

    assign {sif.pc_stall, sif.if_id_stall, sif.id_exe_stall, sif.exe_mem_stall,
            sif.if_id_flush, sif.id_exe_flush, sif.exe_mem_flush, sif.mem_wb_flush} = ctl;
    assign sif.div_busy  = div_busy_w;
    assign sif.stall_cnt = stall_cnt_q;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (ctl[7] && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
`ifdef DIV_STALL_EN
            state_q     <= IDLE;
            div_cnt_q   <= '0;
            div_busy_q  <= 1'b0;
`endif
        end else begin
            stall_cnt_q <= stall_cnt_d;
`ifdef DIV_STALL_EN
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            div_busy_q  <= div_busy_d;
`endif
        end
    end

endmodule

// File: tb/tb_stall_flush_ctrl.sv
// Self-checking bench for stall_flush_ctrl: directed sequences with literal
// expectations plus randomized traffic compared every cycle against a
// behavioural model. Works with or without DIV_STALL_EN defined.
module tb_stall_flush_ctrl;

    localparam int unsigned DIV_N = 33;

    logic clk;
    logic rst_n;
    stall_flush_ctrl_if sif ();

    stall_flush_ctrl #(.DIV_CYCLES(DIV_N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sif   (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [7:0] out_v;
    assign out_v = {sif.pc_stall, sif.if_id_stall, sif.id_exe_stall, sif.exe_mem_stall,
                    sif.if_id_flush, sif.id_exe_flush, sif.exe_mem_flush, sif.mem_wb_flush};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: a source at pipeline depth d (icache=1 .. dcache=4) holds every
    // register in front of it and bubbles the register at depth d.
    function automatic logic [7:0] model_ctl(input logic rst, input logic exc, input logic dc,
                                             input logic busy, input logic haz, input logic ic);
        logic [7:0] v;
        int d;
        v = '0;
        if (!rst) return v;
        if (exc) return 8'h0F;
        d = dc ? 4 : busy ? 3 : haz ? 2 : ic ? 1 : 0;
        for (int i = 0; i < 4; i++)
            if (i < d) v[7 - i] = 1'b1;
        if (d > 0) v[4 - d] = 1'b1;
        return v;
    endfunction

    int          busy_left = 0;   // remaining busy cycles of the modelled divide
    logic [63:0] cnt_m = '0;
    bit          valid = 0;

    always @(negedge clk) begin
        logic       busy_e;
        logic [7:0] e;
`ifdef DIV_STALL_EN
        busy_e = rst_n && (busy_left > 0);
`else
        busy_e = 1'b0;
`endif
        e = model_ctl(rst_n, sif.exc_flush, sif.dcache_stall, busy_e,
                      sif.stcl_lw | sif.stcl_jmp, sif.icache_stall);
        check("ctl_vec", {56'd0, out_v}, {56'd0, e});
        check("div_busy", {63'd0, sif.div_busy}, {63'd0, busy_e});
        if (valid) check("stall_cnt", {32'd0, sif.stall_cnt}, cnt_m);
        // advance model across the coming edge
        if (!rst_n) begin
            busy_left = 0;
            cnt_m     = '0;
            valid     = 1;
        end else begin
            if (e[7] && cnt_m != 64'hFFFF_FFFF) cnt_m = cnt_m + 1;
            if (sif.exc_flush) busy_left = 0;
            else if (busy_left > 0) busy_left--;
            else if (sif.div_start && !sif.dcache_stall) busy_left = DIV_N;
        end
    end

    // v = {rst_n, exc, dc, ds, lw, jmp, ic}
    task automatic set_in(input logic [6:0] v);
        @(posedge clk);
        #1;
        {rst_n, sif.exc_flush, sif.dcache_stall, sif.div_start,
         sif.stcl_lw, sif.stcl_jmp, sif.icache_stall} = v;
    endtask

    task automatic do_reset();
        set_in(7'b0_000000);
        set_in(7'b0_000000);
        set_in(7'b1_000000);
    endtask

    initial begin
        {rst_n, sif.exc_flush, sif.dcache_stall, sif.div_start,
         sif.stcl_lw, sif.stcl_jmp, sif.icache_stall} = 7'b0_000000;

        // reset state
        do_reset();
        @(negedge clk);
        check("rst_cnt", {32'd0, sif.stall_cnt}, 64'd0);
        check("rst_out", {56'd0, out_v}, 64'd0);

        // single load-use hazard
        set_in(7'b1_000100);
        @(negedge clk);
        check("lw_out", {56'd0, out_v}, {56'd0, 8'b1100_0100});
        set_in(7'b1_000000);
        @(negedge clk);
        check("lw_cnt", {32'd0, sif.stall_cnt}, 64'd1);

        // single-source patterns and priority
        set_in(7'b1_100000);
        @(negedge clk);
        check("exc_out", {56'd0, out_v}, {56'd0, 8'b0000_1111});
        set_in(7'b1_010010);
        @(negedge clk);
        check("dc_jmp_out", {56'd0, out_v}, {56'd0, 8'b1111_0001});
        set_in(7'b1_000001);
        @(negedge clk);
        check("ic_out", {56'd0, out_v}, {56'd0, 8'b1000_1000});
        set_in(7'b1_110111);
        @(negedge clk);
        check("exc_prio", {56'd0, out_v}, {56'd0, 8'b0000_1111});

        // counter preload then reset mid-divide (divide only exists in DIV builds)
        do_reset();
        set_in(7'b1_001000);
        @(negedge clk);
        check("ds_idle_out", {56'd0, out_v}, 64'd0);
        for (int i = 0; i < 20; i++) set_in(7'b1_000001);
        set_in(7'b0_000000);
        @(negedge clk);
        check("pre_rst_cnt", {32'd0, sif.stall_cnt}, 64'd20);
        check("in_rst_out", {56'd0, out_v}, 64'd0);
        check("in_rst_busy", {63'd0, sif.div_busy}, 64'd0);
        set_in(7'b1_000000);
        @(negedge clk);
        check("post_rst_cnt", {32'd0, sif.stall_cnt}, 64'd0);
        check("post_rst_busy", {63'd0, sif.div_busy}, 64'd0);

`ifdef DIV_STALL_EN
        begin
            int nbusy;
            bit seen;
            nbusy = 0;
            seen  = 0;
            set_in(7'b1_001000);
            for (int i = 0; i < 80; i++) begin
                if (i == 4)      set_in(7'b1_001000);
                else if (i == 6) set_in(7'b1_010010);
                else             set_in(7'b1_000000);
                @(negedge clk);
                if (sif.div_busy) begin
                    nbusy++;
                    seen = 1;
                    if (i == 6) check("div_dc_out", {56'd0, out_v}, {56'd0, 8'b1111_0001});
                    else        check("div_out", {56'd0, out_v}, {56'd0, 8'b1110_0010});
                end else if (seen) begin
                    break;
                end
            end
            check("div_len", 64'(nbusy), 64'(DIV_N));
        end
        set_in(7'b1_001000);
        for (int i = 0; i < 9; i++) set_in(7'b1_000000);
        set_in(7'b1_100000);
        @(negedge clk);
        check("div_exc_out", {56'd0, out_v}, {56'd0, 8'b0000_1111});
        check("div_exc_busy", {63'd0, sif.div_busy}, 64'd1);
        set_in(7'b1_000000);
        @(negedge clk);
        check("after_exc_busy", {63'd0, sif.div_busy}, 64'd0);
`else
        set_in(7'b1_001000);
        @(negedge clk);
        check("nodiv_out", {56'd0, out_v}, 64'd0);
        for (int i = 0; i < 40; i++) begin
            set_in(7'b1_000000);
            @(negedge clk);
            if (i % 10 == 0) check("nodiv_busy", {63'd0, sif.div_busy}, 64'd0);
        end
`endif

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [6:0] v;
            v[6] = ($urandom_range(99) >= 1);
            v[5] = ($urandom_range(99) < 3);
            v[4] = ($urandom_range(99) < 15);
            v[3] = ($urandom_range(99) < 10);
            v[2] = ($urandom_range(99) < 15);
            v[1] = ($urandom_range(99) < 10);
            v[0] = ($urandom_range(99) < 20);
            set_in(v);
        end
        set_in(7'b1_000000);
        @(negedge clk);
        @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
